// File: rtl/frame_controller_pkg.sv
// frame_controller_pkg: shared widths, latency, FSM states and forwarding encodings
package frame_controller_pkg;
  localparam int REGADDR_WIDTH = 5;
  localparam int DEF_MC_LATENCY = 4;
  localparam int DEF_CNT_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, MC_WAIT = 2'd2} state_e;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;
endpackage

// File: rtl/frame_controller_fwd_compare.sv
// frame_controller_fwd_compare: picks the forwarding source for one decode operand
module frame_controller_fwd_compare
  import frame_controller_pkg::*;
#(
  parameter int W = REGADDR_WIDTH
) (
  input  logic [W-1:0] loc_i,
  input  logic [W-1:0] ex_ws_i,
  input  logic         ex_wen_i,
  input  logic [W-1:0] wb_ws_i,
  input  logic         wb_wen_i,
  output logic [1:0]   sel_o
);
  // EX beats WB; register 0 is never forwarded
  always_comb
    sel_o = (ex_wen_i && ex_ws_i != '0 && loc_i == ex_ws_i) ? FWD_EX :
            (wb_wen_i && wb_ws_i != '0 && loc_i == wb_ws_i) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/frame_controller.sv
// frame_controller: sequences the EX instruction frame and generates operand forwarding
module frame_controller
  import frame_controller_pkg::*;
#(
  parameter int REGADDR_W  = REGADDR_WIDTH,
  parameter int MC_LATENCY = DEF_MC_LATENCY,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REGADDR_W-1:0] dec_aLoc,
  input  logic [REGADDR_W-1:0] dec_bLoc,
  input  logic [REGADDR_W-1:0] dec_writeSelect,
  input  logic                 dec_writeEnable,
  input  logic                 dec_multiCycle,
  input  logic                 flush,
  output logic                 frame_load,
  output logic                 frame_wen_we,
  output logic                 frame_wen_val,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic                 busy
);
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [REGADDR_W-1:0] ex_ws_q, ex_ws_d, wb_ws_q, wb_ws_d;
  logic                 ex_wen_q, ex_wen_d, wb_wen_q, wb_wen_d;
  logic                 accept, bubble, hold;
  logic [1:0]           a_sel, b_sel;

  frame_controller_fwd_compare #(.W(REGADDR_W)) u_fwd_a (
    .loc_i(dec_aLoc), .ex_ws_i(ex_ws_q), .ex_wen_i(ex_wen_q),
    .wb_ws_i(wb_ws_q), .wb_wen_i(wb_wen_q), .sel_o(a_sel)
  );

  frame_controller_fwd_compare #(.W(REGADDR_W)) u_fwd_b (
    .loc_i(dec_bLoc), .ex_ws_i(ex_ws_q), .ex_wen_i(ex_wen_q),
    .wb_ws_i(wb_ws_q), .wb_wen_i(wb_wen_q), .sel_o(b_sel)
  );

  // Handshake and frame enables; every output is forced low while reset is held
  always_comb begin
    dec_ready     = !reset && !flush && (state_q != MC_WAIT || cnt_q == '0);
    hold          = state_q == MC_WAIT && cnt_q != '0 && !flush;
    accept        = dec_valid && dec_ready;
    bubble        = !reset && (flush || (!dec_valid && dec_ready));
    frame_load    = accept;
    frame_wen_we  = accept || bubble;
    frame_wen_val = accept && dec_writeEnable;
    fwd_a_sel     = reset ? FWD_RF : a_sel;
    fwd_b_sel     = reset ? FWD_RF : b_sel;
    busy          = !reset && state_q == MC_WAIT;
  end

  // Next state: flush/bubble, then hold, then accept; bubble and accept shift EX into WB
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_ws_d  = ex_ws_q;
    ex_wen_d = ex_wen_q;
    wb_ws_d  = wb_ws_q;
    wb_wen_d = wb_wen_q;
    if (bubble) begin
      state_d  = IDLE;
      cnt_d    = '0;
      ex_wen_d = 1'b0;
      wb_ws_d  = ex_ws_q;
      wb_wen_d = ex_wen_q;
    end else if (hold) begin
      cnt_d    = cnt_q - CNT_W'(1);
      wb_wen_d = 1'b0;
    end else if (accept) begin
      state_d  = dec_multiCycle ? MC_WAIT : RUN;
      cnt_d    = dec_multiCycle ? CNT_W'(MC_LATENCY - 1) : '0;
      ex_ws_d  = dec_writeSelect;
      ex_wen_d = dec_writeEnable;
      wb_ws_d  = ex_ws_q;
      wb_wen_d = ex_wen_q;
    end
  end

  // State and slot-tracking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ex_ws_q  <= '0;
      ex_wen_q <= 1'b0;
      wb_ws_q  <= '0;
      wb_wen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_ws_q  <= ex_ws_d;
      ex_wen_q <= ex_wen_d;
      wb_ws_q  <= wb_ws_d;
      wb_wen_q <= wb_wen_d;
    end
  end
endmodule
